// File: rtl/dns_cache_resolver.sv
// dns_cache_resolver: resolves a web address through ROOT/TLD/DOMAIN stages,
// each taking STAGE_LAT cycles, and caches {tag, tld, domain, web_ip} in a
// DEPTH-entry fully associative cache. The cache fills the lowest invalid entry
// first. When every entry is valid, it replaces the entry at a round-robin
// victim pointer.
// Optional feature: define DNS_CACHE_STATS_EN to add the hit_cnt/miss_cnt outputs.
module dns_cache_resolver #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int STAGE_LAT = 4,
    parameter int TIME_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              client_req,
    input  logic [ADDR_W-1:0] web_addr,
    input  logic              flush,
    output logic              busy,
    output logic              client_res,
    output logic              ip_resolved,
    output logic              cache_hit,
    output logic [ADDR_W-1:0] tld_addr_out,
    output logic [ADDR_W-1:0] domain_ip_out,
    output logic [ADDR_W-1:0] web_ip_out,
    output logic [TIME_W-1:0] exec_time
`ifdef DNS_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int HALF  = ADDR_W / 2;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STG_W = $clog2(STAGE_LAT + 1);
    localparam logic [TIME_W+1:0] TIME_MAX = {2'b00, {TIME_W{1'b1}}};
    localparam logic [STG_W-1:0]  STG_LAST = STG_W'(STAGE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CACHE,
        ST_ROOT,
        ST_TLD,
        ST_DOMAIN,
        ST_RESP
    } state_t;

    state_t            state_reg;
    logic [STG_W-1:0]  stage_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;

    // Cache storage: valid bits and victim pointer are reset; payload arrays are not.
    logic [DEPTH-1:0]  valid_reg;
    logic [IDX_W-1:0]  victim_reg;
    logic [ADDR_W-1:0] tag_mem [DEPTH];
    logic [ADDR_W-1:0] tld_mem [DEPTH];
    logic [ADDR_W-1:0] dom_mem [DEPTH];
    logic [ADDR_W-1:0] ip_mem  [DEPTH];

    // Resolution arithmetic on the latched address.
    logic [ADDR_W-1:0] calc_tld;
    logic [ADDR_W-1:0] calc_dom;
    logic [ADDR_W-1:0] calc_ip;

    assign calc_tld = {addr_reg[HALF-1:0], addr_reg[ADDR_W-1:HALF]};
    assign calc_dom = calc_tld + addr_reg;
    assign calc_ip  = calc_dom ^ addr_reg;

    // Parallel tag compare against every valid entry.
    logic [DEPTH-1:0] match_vec;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_vec[gi] = valid_reg[gi] && (tag_mem[gi] == addr_reg);
        end
    endgenerate

    // A flush in the compare cycle wipes the cache first, so it forces a miss.
    logic lookup_hit;
    assign lookup_hit = (|match_vec) && !flush;

    // Priority encoders: matching entry for hits, lowest invalid entry for fills.
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic             any_free;

    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit_idx = IDX_W'(i);
            end
            if (!valid_reg[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign any_free = ~&valid_reg;

    logic [IDX_W-1:0] fill_idx;
    logic             fill_en;

    assign fill_idx = any_free ? free_idx : victim_reg;
    // A miss is written back in RESP, unless a flush in the same cycle cancels it.
    assign fill_en  = (state_reg == ST_RESP) && !cache_hit && !flush;

    // Saturating elapsed-cycle increments. +2 also counts the RESP cycle.
    logic [TIME_W+1:0] time_sum1;
    logic [TIME_W+1:0] time_sum2;
    logic [TIME_W-1:0] time_plus1;
    logic [TIME_W-1:0] time_plus2;

    assign time_sum1  = {2'b00, exec_time} + (TIME_W+2)'(1);
    assign time_sum2  = {2'b00, exec_time} + (TIME_W+2)'(2);
    assign time_plus1 = (time_sum1 > TIME_MAX) ? {TIME_W{1'b1}} : time_sum1[TIME_W-1:0];
    assign time_plus2 = (time_sum2 > TIME_W'(0) && time_sum2 > TIME_MAX) ? {TIME_W{1'b1}}
                                                                         : time_sum2[TIME_W-1:0];

    logic stage_last;
    assign stage_last = (stage_cnt_reg == STG_LAST);

    assign busy = (state_reg != ST_IDLE);

    // Lookup FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            stage_cnt_reg <= '0;
            addr_reg      <= '0;
            client_res    <= 1'b0;
            ip_resolved   <= 1'b0;
            cache_hit     <= 1'b0;
            tld_addr_out  <= '0;
            domain_ip_out <= '0;
            web_ip_out    <= '0;
            exec_time     <= '0;
        end else begin
            client_res <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (client_req) begin
                        addr_reg    <= web_addr;
                        exec_time   <= '0;
                        ip_resolved <= 1'b0;
                        state_reg   <= ST_CACHE;
                    end
                end
                ST_CACHE: begin
                    stage_cnt_reg <= '0;
                    if (lookup_hit) begin
                        tld_addr_out  <= tld_mem[hit_idx];
                        domain_ip_out <= dom_mem[hit_idx];
                        web_ip_out    <= ip_mem[hit_idx];
                        cache_hit     <= 1'b1;
                        client_res    <= 1'b1;
                        ip_resolved   <= 1'b1;
                        exec_time     <= time_plus2;
                        state_reg     <= ST_RESP;
                    end else begin
                        exec_time <= time_plus1;
                        state_reg <= ST_ROOT;
                    end
                end
                ST_ROOT: begin
                    exec_time <= time_plus1;
                    if (stage_last) begin
                        stage_cnt_reg <= '0;
                        state_reg     <= ST_TLD;
                    end else begin
                        stage_cnt_reg <= stage_cnt_reg + STG_W'(1);
                    end
                end
                ST_TLD: begin
                    exec_time <= time_plus1;
                    if (stage_last) begin
                        stage_cnt_reg <= '0;
                        tld_addr_out  <= calc_tld;
                        state_reg     <= ST_DOMAIN;
                    end else begin
                        stage_cnt_reg <= stage_cnt_reg + STG_W'(1);
                    end
                end
                ST_DOMAIN: begin
                    if (stage_last) begin
                        stage_cnt_reg <= '0;
                        domain_ip_out <= calc_dom;
                        web_ip_out    <= calc_ip;
                        cache_hit     <= 1'b0;
                        client_res    <= 1'b1;
                        ip_resolved   <= 1'b1;
                        exec_time     <= time_plus2;
                        state_reg     <= ST_RESP;
                    end else begin
                        exec_time     <= time_plus1;
                        stage_cnt_reg <= stage_cnt_reg + STG_W'(1);
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid bits and the round-robin victim pointer. Flush has priority over a fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg  <= '0;
            victim_reg <= '0;
        end else if (flush) begin
            valid_reg  <= '0;
            victim_reg <= '0;
        end else if (fill_en) begin
            valid_reg[fill_idx] <= 1'b1;
            if (!any_free) begin
                victim_reg <= victim_reg + IDX_W'(1);
            end
        end
    end

    // Cache payload write. The valid bit decides whether an entry is usable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx] <= addr_reg;
            tld_mem[fill_idx] <= tld_addr_out;
            dom_mem[fill_idx] <= domain_ip_out;
            ip_mem[fill_idx]  <= web_ip_out;
        end
    end

`ifdef DNS_CACHE_STATS_EN
    // Saturating hit/miss statistics, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_reg == ST_RESP) begin
            if (cache_hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else begin
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dns_cache_resolver.sv
// Testbench for dns_cache_resolver (default parameters).
// Latency is measured from the accepting edge and includes the cycle in which
// client_res is high. With this convention a hit is 2 cycles and a miss is 14.
module tb_dns_cache_resolver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       client_req = 1'b0;
    logic [7:0] web_addr = 8'h00;
    logic       flush = 1'b0;
    logic       busy;
    logic       client_res;
    logic       ip_resolved;
    logic       cache_hit;
    logic [7:0] tld_addr_out;
    logic [7:0] domain_ip_out;
    logic [7:0] web_ip_out;
    logic [7:0] exec_time;
`ifdef DNS_CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dns_cache_resolver #(
        .ADDR_W   (8),
        .DEPTH    (4),
        .STAGE_LAT(4),
        .TIME_W   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .client_req   (client_req),
        .web_addr     (web_addr),
        .flush        (flush),
        .busy         (busy),
        .client_res   (client_res),
        .ip_resolved  (ip_resolved),
        .cache_hit    (cache_hit),
        .tld_addr_out (tld_addr_out),
        .domain_ip_out(domain_ip_out),
        .web_ip_out   (web_ip_out),
        .exec_time    (exec_time)
`ifdef DNS_CACHE_STATS_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Issue one request. Optionally hold flush during the compare cycle.
    // Returns the latency, or -1 on timeout.
    task automatic run_req(input logic [7:0] a, input bit flush_in_cache, output int lat);
        int edges;
        @(negedge clk);
        client_req = 1'b1;
        web_addr   = a;
        @(posedge clk);
        #1;
        client_req = 1'b0;
        if (flush_in_cache) flush = 1'b1;
        edges = 0;
        while (!client_res && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            flush = 1'b0;
        end
        if (!client_res) begin
            checks++;
            failures++;
            $display("FAIL timeout addr=0x%0h actual=no_response expected=client_res", a);
            lat = -1;
        end else begin
            lat = edges + 1;
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    typedef struct {
        logic [7:0] addr;
        bit         flush_before;
        bit         flush_in_cache;
        bit         hit;
        logic [7:0] tld;
        logic [7:0] dom;
        logic [7:0] ip;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int lat;
        int pulses;

        // Expected values are hand computed. For example, 0x9A gives
        // tld=0xA9, dom=0xA9+0x9A=0x43 and ip=0x43^0x9A=0xD9.
        // 0x0n gives tld=0xn0, dom=0xnn and ip=0xn0.
        vecs[0]  = '{8'h9A, 1'b0, 1'b0, 1'b0, 8'hA9, 8'h43, 8'hD9, 14};
        vecs[1]  = '{8'h9A, 1'b0, 1'b0, 1'b1, 8'hA9, 8'h43, 8'hD9, 2};
        vecs[2]  = '{8'h3E, 1'b0, 1'b0, 1'b0, 8'hE3, 8'h21, 8'h1F, 14};
        vecs[3]  = '{8'h3E, 1'b0, 1'b0, 1'b1, 8'hE3, 8'h21, 8'h1F, 2};
        vecs[4]  = '{8'h9A, 1'b1, 1'b0, 1'b0, 8'hA9, 8'h43, 8'hD9, 14};
        vecs[5]  = '{8'h9A, 1'b0, 1'b1, 1'b0, 8'hA9, 8'h43, 8'hD9, 14};
        vecs[6]  = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h10, 8'h11, 8'h10, 14};
        vecs[7]  = '{8'h02, 1'b0, 1'b0, 1'b0, 8'h20, 8'h22, 8'h20, 14};
        vecs[8]  = '{8'h03, 1'b0, 1'b0, 1'b0, 8'h30, 8'h33, 8'h30, 14};
        vecs[9]  = '{8'h04, 1'b0, 1'b0, 1'b0, 8'h40, 8'h44, 8'h40, 14};
        vecs[10] = '{8'h05, 1'b0, 1'b0, 1'b0, 8'h50, 8'h55, 8'h50, 14};
        vecs[11] = '{8'h02, 1'b0, 1'b0, 1'b1, 8'h20, 8'h22, 8'h20, 2};
        vecs[12] = '{8'h01, 1'b0, 1'b0, 1'b0, 8'h10, 8'h11, 8'h10, 14};
        vecs[13] = '{8'h03, 1'b0, 1'b0, 1'b1, 8'h30, 8'h33, 8'h30, 2};

        // Reset state.
        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_client_res", int'(client_res), 0);
        check("reset_ip_resolved", int'(ip_resolved), 0);
        check("reset_exec_time", int'(exec_time), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].flush_before) pulse_flush();
            run_req(vecs[i].addr, vecs[i].flush_in_cache, lat);
            $display("req %0d addr=0x%02h lat=%0d hit=%0d tld=0x%02h dom=0x%02h ip=0x%02h time=%0d",
                     i, vecs[i].addr, lat, cache_hit, tld_addr_out, domain_ip_out, web_ip_out, exec_time);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_cache_hit", i), int'(cache_hit), int'(vecs[i].hit));
            check($sformatf("v%0d_tld", i), int'(tld_addr_out), int'(vecs[i].tld));
            check($sformatf("v%0d_domain", i), int'(domain_ip_out), int'(vecs[i].dom));
            check($sformatf("v%0d_web_ip", i), int'(web_ip_out), int'(vecs[i].ip));
            check($sformatf("v%0d_exec_time", i), int'(exec_time), vecs[i].lat);
            check($sformatf("v%0d_ip_resolved", i), int'(ip_resolved), 1);
            check($sformatf("v%0d_busy_resp", i), int'(busy), 1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_res_pulse", i), int'(client_res), 0);
            check($sformatf("v%0d_busy_after", i), int'(busy), 0);
            check($sformatf("v%0d_resolved_hold", i), int'(ip_resolved), 1);
            check($sformatf("v%0d_time_hold", i), int'(exec_time), vecs[i].lat);
`ifdef DNS_CACHE_STATS_EN
            if (i == 2) begin
                check("stats_hit_cnt", int'(hit_cnt), 1);
                check("stats_miss_cnt", int'(miss_cnt), 2);
            end
`endif
        end

        // A request pulsed while busy is ignored. Expect one response, for 0x3E.
        @(negedge clk);
        client_req = 1'b1;
        web_addr   = 8'h3E;
        @(posedge clk);
        #1;
        client_req = 1'b0;
        check("busy_during_lookup", int'(busy), 1);
        check("resolved_cleared_on_accept", int'(ip_resolved), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        client_req = 1'b1;
        web_addr   = 8'h55;
        @(negedge clk);
        client_req = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (client_res) pulses++;
        end
        $display("busy_seq pulses=%0d ip=0x%02h busy=%0d", pulses, web_ip_out, busy);
        check("busy_single_response", pulses, 1);
        check("busy_web_ip", int'(web_ip_out), 'h1F);
        check("busy_idle_after", int'(busy), 0);

        // Cache 0x9A, then reset in the middle of a 0x77 lookup while in TLD.
        run_req(8'h9A, 1'b0, lat);
        check("pre_reset_9a_latency", lat, 14);
        @(posedge clk);
        @(negedge clk);
        client_req = 1'b1;
        web_addr   = 8'h77;
        @(posedge clk);
        #1;
        client_req = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        $display("reset_seq busy=%0d res=%0d tld=0x%02h dom=0x%02h ip=0x%02h time=%0d",
                 busy, client_res, tld_addr_out, domain_ip_out, web_ip_out, exec_time);
        check("rst_busy", int'(busy), 0);
        check("rst_client_res", int'(client_res), 0);
        check("rst_ip_resolved", int'(ip_resolved), 0);
        check("rst_cache_hit", int'(cache_hit), 0);
        check("rst_tld", int'(tld_addr_out), 0);
        check("rst_domain", int'(domain_ip_out), 0);
        check("rst_web_ip", int'(web_ip_out), 0);
        check("rst_exec_time", int'(exec_time), 0);
`ifdef DNS_CACHE_STATS_EN
        check("rst_hit_cnt", int'(hit_cnt), 0);
        check("rst_miss_cnt", int'(miss_cnt), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (client_res) pulses++;
        end
        check("rst_no_response", pulses, 0);
        run_req(8'h9A, 1'b0, lat);
        $display("post_reset 9a lat=%0d hit=%0d time=%0d", lat, cache_hit, exec_time);
        check("post_rst_latency", lat, 14);
        check("post_rst_cache_hit", int'(cache_hit), 0);
        check("post_rst_web_ip", int'(web_ip_out), 'hD9);
        check("post_rst_exec_time", int'(exec_time), 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dns_cache_resolver.md
DNS_CACHE_RESOLVER -- requirements
Module: dns_cache_resolver

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, width of web address and all resolved addresses (even, at least 4).
REQ-002 Parameter DEPTH SHALL default to 4 and set the number of cache entries (power of 2, at least 2).
REQ-003 Parameter STAGE_LAT SHALL default to 4 and set the cycles spent in each hierarchy stage (at least 1).
REQ-004 Parameter TIME_W SHALL default to 8 and set the width of exec_time.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- client_req  in  1  request strobe.
- web_addr  in  ADDR_W  address to resolve, sampled with client_req.
- flush  in  1  invalidate all cache entries.
- busy  out  1  lookup in progress.
- client_res  out  1  one-cycle response pulse.
- ip_resolved  out  1  result valid, level.
- cache_hit  out  1  last result came from cache.
- tld_addr_out  out  ADDR_W  TLD stage result.
- domain_ip_out  out  ADDR_W  domain stage result.
- web_ip_out  out  ADDR_W  final IP.
- exec_time  out  TIME_W  cycles taken by last lookup.

Function
REQ-006 Resolution arithmetic SHALL be modulo 2^ADDR_W:
- tld = web_addr with upper and lower halves swapped.
- domain = tld + web_addr.
- web_ip = domain XOR web_addr.
REQ-007 FSM states SHALL be IDLE, CACHE, ROOT, TLD, DOMAIN, RESP.
REQ-008 Request acceptance: in IDLE, client_req high at an edge SHALL latch web_addr, clear exec_time, clear ip_resolved, and move to CACHE.
REQ-009 CACHE SHALL last one cycle and compare the latched address against all valid tags in parallel.
- Hit: go to RESP.
- Miss: go to ROOT.
REQ-010 ROOT, TLD and DOMAIN SHALL each last exactly STAGE_LAT cycles, in that order, then go to RESP.
- tld_addr_out updates on leaving TLD.
- domain_ip_out updates on leaving DOMAIN.
REQ-011 RESP SHALL last one cycle, then return to IDLE. During RESP:
- client_res is high.
- ip_resolved rises and stays high until the next accepted request.
- web_ip_out, tld_addr_out, domain_ip_out and cache_hit are valid.
REQ-012 Latency from the accepting edge to client_res high SHALL be 2 cycles on a hit and 2+3*STAGE_LAT cycles on a miss.
REQ-013 exec_time SHALL equal the latency of REQ-012, saturating at 2^TIME_W-1, and hold until the next accepted request.
REQ-014 busy SHALL be high in every state except IDLE.
- client_req while busy is ignored, with no queuing.
REQ-015 On a miss, RESP SHALL write {tag, tld, domain, web_ip} into the first invalid entry (lowest index).
- If no entry is invalid, the write goes to the entry at a round-robin victim pointer, which then increments modulo DEPTH.
REQ-016 A hit SHALL not modify the cache or the victim pointer.
REQ-017 flush SHALL clear all valid bits and reset the victim pointer to 0 at the next edge, in any state.
- flush in the same cycle as a RESP fill wins: the entry is not written.
- The in-flight response is still delivered.
REQ-018 flush during CACHE SHALL be applied before the compare, forcing a miss.

Reset
REQ-019 When rst is low, the following SHALL be cleared immediately, independent of clk:
- state to IDLE.
- busy, client_res, ip_resolved and cache_hit to 0.
- tld_addr_out, domain_ip_out, web_ip_out and exec_time to 0.
- all valid bits and the victim pointer to 0.
REQ-020 Reset mid-lookup SHALL abort the lookup with no response and no cache write.
- The first request after rst deasserts is accepted normally.

Configuration
REQ-021 With DNS_CACHE_STATS_EN defined, the block SHALL add two outputs, both reset to 0 and cleared by rst only:
- hit_cnt, 16 bits, counting cache hits.
- miss_cnt, 16 bits, counting misses.
- Both increment in RESP and saturate at 0xFFFF.
REQ-022 Without DNS_CACHE_STATS_EN, these ports and their counters SHALL be absent and all other behaviour SHALL be identical.

Verification (defaults: ADDR_W=8, DEPTH=4, STAGE_LAT=4)
REQ-023 First request for address 0x9A SHALL miss:
- client_res 14 cycles after acceptance.
- tld=0xA9, domain=0x43, web_ip=0xD9.
- cache_hit=0, exec_time=14.
REQ-024 Repeated request for 0x9A SHALL hit:
- client_res 2 cycles after acceptance.
- web_ip=0xD9, cache_hit=1, exec_time=2.
REQ-025 Request for 0x3E SHALL miss: tld=0xE3, domain=0x21, web_ip=0x1F, exec_time=14.
REQ-026 Fill and eviction:
- Fill 0x01, 0x02, 0x03, 0x04; then request 0x05, which evicts entry 0 (0x01).
- A subsequent 0x01 misses; 0x02 hits.
REQ-027 Busy, flush and reset:
- client_req for 0x3E pulsed while busy: ignored, only one client_res.
- flush, then request 0x9A: miss, exec_time=14.
- rst low during TLD: outputs 0, no client_res, and the next 0x9A misses.
REQ-028 With DNS_CACHE_STATS_EN defined, the sequence 0x9A, 0x9A, 0x3E SHALL end with hit_cnt=1 and miss_cnt=2.
